// File: rtl/vga_pkg.sv
// Shared constants and enums for the VGA frame-buffer arbiter.
// Optional macro VGA_FB_VBLANK_WR_EN is consumed by vga_fb_arbiter.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_CPU
  } owner_t;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } fb_state_t;
endpackage

// File: rtl/vga_fb_addr_gen.sv
// Frame-buffer coordinate to linear address: y*160 + x via shifts.
// Shared with the CPU-side drawing code.
module vga_fb_addr_gen #(
  parameter int XW     = 8,
  parameter int YW     = 8,
  parameter int ADDR_W = 15
) (
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W-1:0] xe;
  logic [ADDR_W-1:0] ye;

  assign xe   = ADDR_W'(x);
  assign ye   = ADDR_W'(y);
  assign addr = (ye << 7) + (ye << 5) + xe;
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display slots, clear engine, CPU.
// Define VGA_FB_VBLANK_WR_EN to restrict writes to vertical blanking.
module vga_fb_arbiter #(
  parameter int SCALE_SHIFT = 2,
  parameter int DATA_W      = 24,
  parameter int ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        counter_x,
  input  logic [9:0]        counter_y,
  input  logic              in_display_area,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_color,
  output logic              pix_valid
);
  import vga_pkg::*;

  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(FB_DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(FB_DEPTH);

  fb_state_t         state, state_nx;
  owner_t            tag, tag_nx;
  logic              oob, oob_cur;
  logic [ADDR_W-1:0] clr_addr, disp_addr;
  logic [DATA_W-1:0] clr_col;
  logic [1:0]        pv;
  logic              slot, wr_ok, clr_wr, clr_last;

  vga_fb_addr_gen #(
    .XW     (10),
    .YW     (10),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .x    (counter_x >> SCALE_SHIFT),
    .y    (counter_y >> SCALE_SHIFT),
    .addr (disp_addr)
  );

`ifdef VGA_FB_VBLANK_WR_EN
  assign wr_ok = counter_y >= 10'(V_ACTIVE);
`else
  assign wr_ok = 1'b1;
`endif

  assign slot     = !rst && in_display_area &&
                    counter_x[SCALE_SHIFT-1:0] == '0;
  assign clr_busy = state == ST_CLEAR;
  assign clr_wr   = !rst && clr_busy && !slot && wr_ok;
  assign clr_last = clr_addr == LAST;
  assign oob_cur  = cpu_addr >= DEPTH;
  // Clear owns the port for its whole run, even while paused.
  assign cpu_gnt  = !rst && cpu_req && !slot && !clr_busy &&
                    (!cpu_we || wr_ok);
  assign pix_valid = pv[1];

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_nx    = OWN_NONE;
    state_nx  = state;
    unique case (1'b1)
      slot: begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
        tag_nx   = OWN_DISP;
      end
      clr_wr: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_addr;
        mem_wdata = clr_col;
      end
      cpu_gnt: begin
        mem_en    = !oob_cur;
        mem_we    = cpu_we && !oob_cur;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        tag_nx    = cpu_we ? OWN_NONE : OWN_CPU;
      end
      default: ;
    endcase
    unique case (state)
      ST_IDLE:  if (clr_start) state_nx = ST_CLEAR;
      ST_CLEAR: if (clr_wr && clr_last) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr   <= '0;
      clr_col    <= '0;
      tag        <= OWN_NONE;
      oob        <= 1'b0;
      pv         <= '0;
      pix_color  <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      clr_done   <= 1'b0;
    end else begin
      clr_done <= clr_wr && clr_last;
      if (state == ST_IDLE && clr_start) begin
        clr_col  <= clr_color;
        clr_addr <= '0;
      end else if (clr_wr) begin
        clr_addr <= clr_last ? '0 : clr_addr + 1'b1;
      end
      tag        <= tag_nx;
      oob        <= oob_cur;
      pv         <= {pv[0], in_display_area};
      cpu_rvalid <= tag == OWN_CPU;
      if (tag == OWN_DISP) pix_color <= mem_rdata;
      if (tag == OWN_CPU)  cpu_rdata <= oob ? '0 : mem_rdata;
    end
  end
endmodule
